// File: rtl/serial_add_sub_pkg.sv
// Shared types and elaboration checks for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 64;

  function automatic bit width_ok(input int unsigned w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Combinational one-bit full adder; the only arithmetic cell in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, WIDTH cycles per result,
// valid/ready handshakes on operand and result sides.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             C_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("serial_add_sub: WIDTH must be in 2..64");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             w_sum;
  logic             w_co;

  fa_cell u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  assign start_ready = (r_state == IDLE);
  assign done_valid  = (r_state == DONE);
  assign busy        = (r_state != IDLE);

  // Subtraction is A + ~B + ~borrow_in; carry out is inverted back into a borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      S       <= '0;
      C_out   <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{sub}};
            r_sub   <= sub;
            r_carry <= C_in ^ sub;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_s     <= {w_sum, r_s[WIDTH-1:1]};
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB; XOR with carry out gives overflow.
            S       <= {w_sum, r_s[WIDTH-1:1]};
            C_out   <= w_co ^ r_sub;
            V       <= r_carry ^ w_co;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: WIDTH=8 vectors, backpressure, reset abort,
// and an exhaustive WIDTH=4 sweep against an integer reference.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sv8 = 1'b0, sr8, sub8 = 1'b0, cin8 = 1'b0, dv8, dr8 = 1'b0;
  logic       c8, v8, busy8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  logic       sv4 = 1'b0, sr4, sub4 = 1'b0, cin4 = 1'b0, dv4, dr4 = 1'b0;
  logic       c4, v4, busy4;
  logic [3:0] a4 = '0, b4 = '0, s4;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .A(a8), .B(b8),
    .sub(sub8), .C_in(cin8), .done_valid(dv8), .done_ready(dr8), .S(s8),
    .C_out(c8), .V(v8), .busy(busy8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .A(a4), .B(b4),
    .sub(sub4), .C_in(cin4), .done_valid(dv4), .done_ready(dr4), .S(s4),
    .C_out(c4), .V(v4), .busy(busy4)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in IDLE; returns with the result presented (or after a bounded wait).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic ci, output int lat);
    sv8 = 1'b1; a8 = a; b8 = b; sub8 = m; cin8 = ci;
    tick();
    sv8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~m; cin8 = ~ci;
    lat = 0;
    while (!dv8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take8();
    dr8 = 1'b1;
    tick();
    dr8 = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int acc, last_acc;
    bit have_last;
    int sa, sb, u, r;
    logic [3:0] es;
    logic ec, ev;

    // Reset values, before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_S", s8, 8'h00);
    chk("rst_Cout", c8, 1'b0);
    chk("rst_V", v8, 1'b0);
    chk("rst_done_valid", dv8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_start_ready", sr8, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Add 3C+5A: signed overflow, latency WIDTH
    run8(8'h3C, 8'h5A, 1'b0, 1'b0, lat);
    chk("add1_latency", lat, 8);
    chk("add1_S", s8, 8'h96);
    chk("add1_Cout", c8, 1'b0);
    chk("add1_V", v8, 1'b1);
    take8();

    run8(8'hFF, 8'h01, 1'b0, 1'b1, lat);
    chk("add2_S", s8, 8'h01);
    chk("add2_Cout", c8, 1'b1);
    chk("add2_V", v8, 1'b0);
    take8();

    run8(8'h10, 8'h20, 1'b1, 1'b0, lat);
    chk("sub1_S", s8, 8'hF0);
    chk("sub1_borrow", c8, 1'b1);
    chk("sub1_V", v8, 1'b0);
    take8();

    // Sub 80-01 then hold off done_ready with start_valid pulsed
    run8(8'h80, 8'h01, 1'b1, 1'b0, lat);
    chk("sub2_S", s8, 8'h7F);
    chk("sub2_borrow", c8, 1'b0);
    chk("sub2_V", v8, 1'b1);
    sv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_done_valid", dv8, 1'b1);
      chk("bp_S", s8, 8'h7F);
      chk("bp_Cout", c8, 1'b0);
      chk("bp_V", v8, 1'b1);
      chk("bp_start_ready", sr8, 1'b0);
      chk("bp_busy", busy8, 1'b1);
    end
    sv8 = 1'b0;
    take8();
    chk("idle_done_valid", dv8, 1'b0);
    chk("idle_busy", busy8, 1'b0);
    chk("idle_S_hold", s8, 8'h7F);
    tick();
    chk("idle_no_spurious", busy8, 1'b0);

    // start_valid during RUN is not accepted and inputs are ignored
    sv8 = 1'b1; a8 = 8'h21; b8 = 8'h43; sub8 = 1'b0; cin8 = 1'b0;
    tick();
    a8 = 8'hEE; b8 = 8'hEE; sub8 = 1'b1; cin8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_start_ready", sr8, 1'b0);
      chk("run_busy", busy8, 1'b1);
    end
    sv8 = 1'b0;
    n = 0;
    while (!dv8 && n < 20) begin tick(); n++; end
    chk("run_ign_S", s8, 8'h64);
    chk("run_ign_Cout", c8, 1'b0);
    take8();
    chk("run_ign_idle", sr8, 1'b1);

    // Reset abort in the 4th RUN cycle
    sv8 = 1'b1; a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0;
    tick();
    sv8 = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_busy", busy8, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_S", s8, 8'h00);
    chk("abort_done_valid", dv8, 1'b0);
    chk("abort_start_ready", sr8, 1'b1);
    chk("abort_busy", busy8, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_result", dv8, 1'b0);
    run8(8'h01, 8'h01, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_S", s8, 8'h02);
    take8();

    // WIDTH=4 exhaustive, back-to-back with done_ready held
    dr4 = 1'b1;
    have_last = 1'b0;
    last_acc = 0;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          for (int c = 0; c < 2; c++) begin
            a4 = a[3:0]; b4 = b[3:0]; sub4 = m[0]; cin4 = c[0]; sv4 = 1'b1;
            n = 0;
            while (!sr4 && n < 20) begin tick(); n++; end
            tick();
            acc = cyc;
            sv4 = 1'b0;
            if (have_last) chk("w4_interval", acc - last_acc, 6);
            last_acc = acc;
            have_last = 1'b1;
            n = 0;
            while (!dv4 && n < 20) begin tick(); n++; end
            sa = (a > 7) ? a - 16 : a;
            sb = (b > 7) ? b - 16 : b;
            if (m == 0) begin
              u  = a + b + c;
              es = 4'(u % 16);
              ec = (u > 15);
              r  = sa + sb + c;
            end else begin
              u  = a - b - c + 32;
              es = 4'(u % 16);
              ec = (a < b + c);
              r  = sa - sb - c;
            end
            ev = (r > 7) || (r < -8);
            chk($sformatf("w4_m%0d_a%0h_b%0h_c%0d", m, a, b, c),
                {dv4, s4, c4, v4}, {1'b1, es, ec, ev});
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
